// File: rtl/dmem_pkg.sv
// Shared definitions for the lane-aware data memory: access size codes, FSM states
// and the fixed datapath width.
package dmem_pkg;

  localparam int unsigned DMEM_D_WIDTH = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  localparam logic ST_CLEAR = 1'b0;
  localparam logic ST_IDLE  = 1'b1;

endpackage

// File: rtl/dmem_lane_ctrl_if.sv
// Request/response bundle for dmem_lane_ctrl. With DMEM_PARITY_EN defined the bundle
// also carries o_parity_err.
interface dmem_lane_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 10
);

  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_write;
  logic                  i_read;
  logic [1:0]            i_size;
  logic                  i_unsigned;
  logic [31:0]           i_data;
  logic [31:0]           o_data;
  logic                  o_valid;
  logic                  o_misalign;
  logic                  o_busy;
`ifdef DMEM_PARITY_EN
  logic                  o_parity_err;
`endif

  modport master (
    output i_addr, i_write, i_read, i_size, i_unsigned, i_data,
`ifdef DMEM_PARITY_EN
    input  o_parity_err,
`endif
    input  o_data, o_valid, o_misalign, o_busy
  );

  modport slave (
    input  i_addr, i_write, i_read, i_size, i_unsigned, i_data,
`ifdef DMEM_PARITY_EN
    output o_parity_err,
`endif
    output o_data, o_valid, o_misalign, o_busy
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte-enables and data replication, load lane
// extraction with sign/zero extension, and alignment/legality checking.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  lane_mask_o,
  output logic [31:0] wdata_rep_o,
  output logic [31:0] rdata_ext_o,
  output logic        misalign_o
);

  logic [31:0] shifted;
  logic [3:0]  mask_raw;

  always_comb begin
    mask_raw    = 4'b0000;
    wdata_rep_o = wdata_i;
    rdata_ext_o = rword_i;
    misalign_o  = 1'b0;
    // Bring the addressed lane down to bit 0 before extension.
    shifted     = rword_i >> {addr_lo_i, 3'b000};
    unique case (size_e'(size_i))
      SZ_BYTE: begin
        mask_raw    = 4'b0001 << addr_lo_i;
        wdata_rep_o = {4{wdata_i[7:0]}};
        rdata_ext_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        misalign_o  = addr_lo_i[0];
        mask_raw    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_rep_o = {2{wdata_i[15:0]}};
        rdata_ext_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
      end
      SZ_WORD: begin
        misalign_o = |addr_lo_i;
        mask_raw   = 4'b1111;
      end
      default: begin
        misalign_o = 1'b1;
      end
    endcase
    lane_mask_o = misalign_o ? 4'b0000 : mask_raw;
  end

endmodule

// File: rtl/dmem_lane_ctrl.sv
// Word-organised data RAM with byte/half/word lanes, registered one-cycle loads and a
// post-reset clearing sweep. Optional per-lane parity under DMEM_PARITY_EN.
module dmem_lane_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned D_WIDTH    = 32
) (
  input logic             i_clk,
  input logic             i_rst_n,
  dmem_lane_ctrl_if.slave bus
);

  localparam int unsigned IDX_W = ADDR_WIDTH - 2;

  if (D_WIDTH != DMEM_D_WIDTH) begin : g_bad_dwidth
    $error("dmem_lane_ctrl: D_WIDTH must be 32");
  end
  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("dmem_lane_ctrl: DEPTH must be a power of two, at least 4");
  end
  if (ADDR_WIDTH != $clog2(DEPTH) + 2) begin : g_bad_awidth
    $error("dmem_lane_ctrl: ADDR_WIDTH must equal clog2(DEPTH)+2");
  end

  logic             state_q, state_d;
  logic [IDX_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [31:0]      data_q, data_d;
  logic             valid_q, valid_d;
  logic             mis_q, mis_d;

  logic [31:0]      mem [DEPTH];
  logic [IDX_W-1:0] idx;
  logic [31:0]      rword;
  logic [31:0]      wdata_rep;
  logic [31:0]      rdata_ext;
  logic [3:0]       lane_mask;
  logic             misalign;
  logic             req;
  logic             do_wr;
  logic             do_rd;

  assign idx   = bus.i_addr[ADDR_WIDTH-1:2];
  assign rword = mem[idx];

  dmem_lane_align u_align (
    .addr_lo_i   (bus.i_addr[1:0]),
    .size_i      (bus.i_size),
    .unsigned_i  (bus.i_unsigned),
    .wdata_i     (bus.i_data),
    .rword_i     (rword),
    .lane_mask_o (lane_mask),
    .wdata_rep_o (wdata_rep),
    .rdata_ext_o (rdata_ext),
    .misalign_o  (misalign)
  );

  // Requests only count once the sweep has finished.
  assign req   = (state_q == ST_IDLE) && (bus.i_read || bus.i_write);
  assign do_wr = req && bus.i_write && !misalign;
  assign do_rd = req && bus.i_read && !misalign;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    data_d    = data_q;
    valid_d   = do_rd;
    mis_d     = req && misalign;
    if (state_q == ST_CLEAR) begin
      clr_ptr_d = clr_ptr_q + IDX_W'(1);
      if (clr_ptr_q == IDX_W'(DEPTH - 1)) begin
        state_d = ST_IDLE;
      end
    end
    if (do_rd) begin
      data_d = rdata_ext;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      mis_q     <= mis_d;
    end
  end

  // Array has no reset; the sweep provides the known contents.
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      if (state_q == ST_CLEAR) begin
        mem[clr_ptr_q] <= '0;
      end else if (do_wr) begin
        for (int b = 0; b < 4; b++) begin
          if (lane_mask[b]) begin
            mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
          end
        end
      end
    end
  end

`ifdef DMEM_PARITY_EN
  logic [3:0] par_mem [DEPTH];
  logic [3:0] par_calc;
  logic       perr_q, perr_d;

  always_comb begin
    par_calc = '0;
    for (int b = 0; b < 4; b++) begin
      par_calc[b] = ^rword[8*b +: 8];
    end
  end

  assign perr_d = do_rd && (|((par_calc ^ par_mem[idx]) & lane_mask));

  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      if (state_q == ST_CLEAR) begin
        par_mem[clr_ptr_q] <= '0;
      end else if (do_wr) begin
        for (int b = 0; b < 4; b++) begin
          if (lane_mask[b]) begin
            par_mem[idx][b] <= ^wdata_rep[8*b +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign bus.o_parity_err = perr_q;
`endif

  assign bus.o_data     = data_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_misalign = mis_q;
  assign bus.o_busy     = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_dmem_lane_ctrl.sv
// Bench for dmem_lane_ctrl: byte-addressed reference model checked every cycle, plus
// directed literal checks and randomized traffic.
module tb_dmem_lane_ctrl;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 10;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  dmem_lane_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  dmem_lane_ctrl #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW),
    .D_WIDTH    (32)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: memory as a flat byte array, outputs as plain variables.
  logic [7:0]  mb [DEPTH*4];
  int          sweep_left;
  bit          armed;
  logic        exp_valid;
  logic        exp_mis;
  logic [31:0] exp_data;

  always @(posedge clk) begin
    logic [AW-1:0] a;
    logic [1:0]    sz;
    logic          legal;
    a  = bus.i_addr;
    sz = bus.i_size;
    if (!rst_n) begin
      armed      = 1'b1;
      sweep_left = DEPTH;
      exp_valid  = 1'b0;
      exp_mis    = 1'b0;
      exp_data   = '0;
    end else if (armed) begin
      if (sweep_left > 0) begin
        sweep_left--;
        exp_valid = 1'b0;
        exp_mis   = 1'b0;
        if (sweep_left == 0) begin
          for (int i = 0; i < DEPTH * 4; i++) mb[i] = 8'h00;
        end
      end else begin
        legal = (sz == 2'd0) || (sz == 2'd1 && a[0] == 1'b0) ||
                (sz == 2'd2 && a[1:0] == 2'd0);
        if ((bus.i_read || bus.i_write) && !legal) begin
          exp_mis   = 1'b1;
          exp_valid = 1'b0;
        end else begin
          exp_mis   = 1'b0;
          exp_valid = bus.i_read;
          if (bus.i_read) begin
            case (sz)
              2'd0: exp_data = bus.i_unsigned ? 32'(mb[a]) : 32'($signed(mb[a]));
              2'd1: exp_data = bus.i_unsigned ? 32'({mb[a+1], mb[a]})
                                              : 32'($signed({mb[a+1], mb[a]}));
              default: exp_data = {mb[a+3], mb[a+2], mb[a+1], mb[a]};
            endcase
          end
          if (bus.i_write) begin
            for (int i = 0; i < (1 << sz); i++) mb[a + AW'(i)] = bus.i_data[8*i +: 8];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("busy", 32'(bus.o_busy), 32'(sweep_left > 0));
      check("valid", 32'(bus.o_valid), 32'(exp_valid));
      check("misalign", 32'(bus.o_misalign), 32'(exp_mis));
      check("data", bus.o_data, exp_data);
`ifdef DMEM_PARITY_EN
      check("parity_err", 32'(bus.o_parity_err), 32'(0));
`endif
    end
  end

  task automatic drive(input logic wr, input logic rd, input logic [AW-1:0] a,
                       input logic [1:0] sz, input logic uns, input logic [31:0] d);
    bus.i_write    = wr;
    bus.i_read     = rd;
    bus.i_addr     = a;
    bus.i_size     = sz;
    bus.i_unsigned = uns;
    bus.i_data     = d;
  endtask

  task automatic idle();
    bus.i_write = 1'b0;
    bus.i_read  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [AW-1:0] a, input logic [1:0] sz, input logic [31:0] d);
    drive(1'b1, 1'b0, a, sz, 1'b0, d);
    tick();
    idle();
  endtask

  task automatic load_chk(input string name, input logic [AW-1:0] a, input logic [1:0] sz,
                          input logic uns, input logic [31:0] exp);
    drive(1'b0, 1'b1, a, sz, uns, 32'h0);
    tick();
    check({name, "_valid"}, 32'(bus.o_valid), 32'd1);
    check(name, bus.o_data, exp);
    idle();
  endtask

  task automatic bad_chk(input string name, input logic wr, input logic rd,
                         input logic [AW-1:0] a, input logic [1:0] sz);
    drive(wr, rd, a, sz, 1'b0, 32'hCAFEF00D);
    tick();
    check({name, "_mis"}, 32'(bus.o_misalign), 32'd1);
    check({name, "_valid"}, 32'(bus.o_valid), 32'd0);
    idle();
  endtask

  task automatic rand_req();
    logic [1:0]    sz;
    logic [AW-1:0] a;
    int            r;
    r  = int'($urandom_range(0, 7));
    sz = (r < 3) ? 2'd0 : (r < 5) ? 2'd1 : (r < 7) ? 2'd2 : 2'd3;
    a  = AW'($urandom_range(0, 127));
    if ($urandom_range(0, 3) != 0) begin
      if (sz == 2'd1) a[0] = 1'b0;
      if (sz == 2'd2) a[1:0] = 2'b00;
    end
    drive(1'($urandom), 1'($urandom), a, sz, 1'($urandom), $urandom);
  endtask

  initial begin
    int n;
    clk   = 1'b0;
    rst_n = 1'b0;
    tests = 0;
    fails = 0;
    armed = 1'b0;
    drive(1'b0, 1'b0, '0, 2'd0, 1'b0, 32'h0);

    tick();
    check("rst_busy", 32'(bus.o_busy), 32'd1);
    check("rst_valid", 32'(bus.o_valid), 32'd0);
    check("rst_mis", 32'(bus.o_misalign), 32'd0);
    check("rst_data", bus.o_data, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;

    n = 0;
    do begin
      tick();
      n++;
    end while (bus.o_busy && n < 1000);
    check("sweep_len", 32'(n), 32'd256);
    load_chk("clr_3fc", 10'h3FC, 2'd2, 1'b0, 32'h0000_0000);

    store(10'h010, 2'd2, 32'h80FF7F01);
    load_chk("sb10", 10'h010, 2'd0, 1'b0, 32'h0000_0001);
    load_chk("sb11", 10'h011, 2'd0, 1'b0, 32'h0000_007F);
    load_chk("sb12", 10'h012, 2'd0, 1'b0, 32'hFFFF_FFFF);
    load_chk("sb13", 10'h013, 2'd0, 1'b0, 32'hFFFF_FF80);
    load_chk("ub10", 10'h010, 2'd0, 1'b1, 32'h0000_0001);
    load_chk("ub11", 10'h011, 2'd0, 1'b1, 32'h0000_007F);
    load_chk("ub12", 10'h012, 2'd0, 1'b1, 32'h0000_00FF);
    load_chk("ub13", 10'h013, 2'd0, 1'b1, 32'h0000_0080);

    store(10'h020, 2'd2, 32'h11223344);
    store(10'h022, 2'd1, 32'h0000BEEF);
    load_chk("w20", 10'h020, 2'd2, 1'b1, 32'hBEEF_3344);
    load_chk("sh22", 10'h022, 2'd1, 1'b0, 32'hFFFF_BEEF);
    load_chk("uh20", 10'h020, 2'd1, 1'b1, 32'h0000_3344);

    bad_chk("sw05", 1'b1, 1'b0, 10'h005, 2'd2);
    bad_chk("lh03", 1'b0, 1'b1, 10'h003, 2'd1);
    bad_chk("rsvd", 1'b0, 1'b1, 10'h010, 2'd3);
    load_chk("w04_kept", 10'h004, 2'd2, 1'b0, 32'h0000_0000);
    load_chk("w10_kept", 10'h010, 2'd2, 1'b0, 32'h80FF_7F01);

    store(10'h040, 2'd2, 32'h0000002D);
    drive(1'b1, 1'b1, 10'h040, 2'd2, 1'b0, 32'h00000055);
    tick();
    check("rbw_valid", 32'(bus.o_valid), 32'd1);
    check("rbw_old", bus.o_data, 32'h0000_002D);
    idle();
    load_chk("rbw_new", 10'h040, 2'd2, 1'b0, 32'h0000_0055);

    for (int i = 0; i < 3000; i++) begin
      rand_req();
      tick();
    end
    idle();

    // Restart the sweep part way through, with traffic present the whole time.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      rand_req();
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n = 0;
    do begin
      drive(1'b1, 1'b1, AW'((n % 16) * 4), 2'd2, 1'b0, 32'hDEAD0000 | 32'(n));
      tick();
      n++;
    end while (bus.o_busy && n < 1000);
    idle();
    check("sweep_len_restart", 32'(n), 32'd256);
    load_chk("after_w00", 10'h000, 2'd2, 1'b0, 32'h0000_0000);
    load_chk("after_w3c", 10'h03C, 2'd2, 1'b0, 32'h0000_0000);
    load_chk("after_w10", 10'h010, 2'd2, 1'b0, 32'h0000_0000);

    for (int i = 0; i < 500; i++) begin
      rand_req();
      tick();
    end
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
